contador_ud_bcd: RTL and testbench
==================================

# contador_ud_bcd

Two-digit BCD up/down counter that consumes the slow square wave produced by the clock divider, counts one step per slow-clock period, and drives a multiplexed two-digit common-anode 7-segment display. It runs entirely on the board clock, never on the divided clock. The slow clock enters as an ordinary data input and is converted to a one-cycle tick. This is the counting and display stage of the up/down counter design.

## Interface
- REFRESH_DIV, 50000: board-clock cycles per display digit slot (1 kHz per digit at 50 MHz); minimum 2.
- clock_in  input  1  board clock; the only clock.
- reset  input  1  synchronous, active-high.
- clk_slow  input  1  divider output, treated as asynchronous data.
- dir  input  1  1 = count up, 0 = count down; asynchronous switch.
- enable  input  1  1 = count on tick; asynchronous switch.
- tens  output  4  BCD tens digit, 0–9.
- units  output  4  BCD units digit, 0–9.
- wrap  output  1  one-cycle pulse on 99→00 (up) or 00→99 (down).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  2  digit anodes, active-low; an[0] = units, an[1] = tens.

## Operation
- Input conditioning:
  - clk_slow passes through a two-flop synchronizer (s1, s2) plus a history flop s3.
  - tick = s2 & ~s3.
  - dir and enable each pass through their own two-flop synchronizer. Only the synchronized values are used.
- Counting, on a cycle with tick = 1 and synchronized enable = 1:
  - up: units 0–8 → units+1. Units 9 → 0 and tens+1. At 99 → 00 with wrap = 1.
  - down: units 1–9 → units−1. Units 0 → 9 and tens−1. At 00 → 99 with wrap = 1.
  - tick with enable = 0: count holds and no wrap.
- Direction change in the same cycle as a tick: the synchronized dir value present in the tick cycle decides.
- Digits never leave 0–9. Non-BCD values are unreachable.
- Display:
  - The refresh counter counts 0..REFRESH_DIV−1 and then wraps.
  - On wrap, sel toggles.
  - sel = 0: an = 2'b10, seg = pattern(units). sel = 1: an = 2'b01, seg = pattern(tens).
- Reset (any cycle, including mid-count or mid-refresh):
  - Cleared to 0: tens, units, wrap, refresh counter, sel, and the dir/enable synchronizers.
  - s1, s2, s3 are set to 1. This prevents a spurious tick when clk_slow is high at reset release.

## Timing
- Reset values:
  - tens = 0, units = 0, wrap = 0, an = 2'b10.
  - seg = 7'b1000000 ("0", registered).
- Tick latency:
  - A clk_slow rise sampled at clock edge N gives tick = 1 in the cycle after edge N+2.
  - tens/units update and wrap pulses at edge N+3.
  - Exactly one count per clk_slow rising edge.
- Synchronizer latency: a dir or enable change affects counting 2 edges after sampling.
- Outputs:
  - tens, units, wrap: registered.
  - seg, an: registered; they change on the same edge as sel, or one edge after a count update.
- wrap is high for exactly one clock_in cycle per wrap event.
- A clk_slow high at reset release gives no tick until a genuine low→high transition.

## Structure
- Shared package/header ud_defs:
  - 7-segment active-low patterns for 0–9, plus blank = 7'b1111111.
  - BCD digit width (4).
  - Anode codes AN_UNITS = 2'b10, AN_TENS = 2'b01.
- Sub-module bcd_to_7seg: purely combinational 4-bit → 7-bit decoder. Inputs 10–15 produce blank. One instance, fed by the sel mux.
- Top-level blocks: synchronizers and edge detector, BCD counter, refresh/multiplex logic.

## Test plan
All tests use REFRESH_DIV = 4 and clk_slow period 20 clock_in cycles.
- Reset then 12 clk_slow rises, dir = 1, enable = 1 → count 12. Each update exactly 3 edges after the sampled rise.
- Preload to 97 by counting up, then 3 rises → 98, 99, 00. wrap is 1 for one cycle only, on the 99→00 edge.
- From 00, dir = 0, 2 rises → 99 with wrap pulse, then 98. At 10, one rise → 09.
- enable = 0 for 5 rises → count frozen, wrap = 0. dir toggled exactly on the tick cycle → the synchronized value decides.
- Display:
  - Count 37: an alternates 10/01 every 4 cycles.
  - seg = 7'b1111000 ("7") with an = 10.
  - seg = 7'b0110000 ("3") with an = 01.
- Reset mid-count at 45 with clk_slow held high → 00 on the next edge, and no tick until clk_slow goes low then high.

Source files
------------

// File: rtl/ud_defs_pkg.sv
// Shared constants for the BCD up/down counter: digit width, anode codes
// and the active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package ud_defs;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic {
    SEL_UNITS = 1'b0,
    SEL_TENS  = 1'b1
  } digit_sel_t;

  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic logic [6:0] seg_pattern(input bcd_t digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes blank.
module bcd_to_7seg
  import ud_defs::*;
(
  input  logic [3:0] digit,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = seg_pattern(digit);
  end

endmodule

// File: rtl/contador_ud_bcd.sv
// Two-digit BCD up/down counter stepped by the divided clock (sampled as
// data on the board clock) and driving a multiplexed common-anode display.
module contador_ud_bcd
  import ud_defs::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       clk_slow,
  input  logic       dir,
  input  logic       enable,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       wrap,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  // ---------------- input conditioning ----------------
  logic [1:0] async_in;
  logic [1:0] sync_out;
  logic       dir_sync;
  logic       en_sync;

  assign async_in = {enable, dir};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic stable_reg;
      always_ff @(posedge clock_in) begin
        if (reset) begin
          meta_reg   <= 1'b0;
          stable_reg <= 1'b0;
        end else begin
          meta_reg   <= async_in[gi];
          stable_reg <= meta_reg;
        end
      end
      assign sync_out[gi] = stable_reg;
    end
  endgenerate

  assign dir_sync = sync_out[0];
  assign en_sync  = sync_out[1];

  // Edge history resets high so a slow clock already high at release is not a rise.
  logic slow_s1_reg, slow_s2_reg, slow_s3_reg;
  logic tick_reg;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      slow_s1_reg <= 1'b1;
      slow_s2_reg <= 1'b1;
      slow_s3_reg <= 1'b1;
      tick_reg    <= 1'b0;
    end else begin
      slow_s1_reg <= clk_slow;
      slow_s2_reg <= slow_s1_reg;
      slow_s3_reg <= slow_s2_reg;
      tick_reg    <= slow_s2_reg & ~slow_s3_reg;
    end
  end

  // ---------------- BCD counter ----------------
  bcd_t tens_reg, tens_next;
  bcd_t units_reg, units_next;
  logic wrap_reg, wrap_next;

  always_comb begin
    tens_next  = tens_reg;
    units_next = units_reg;
    wrap_next  = 1'b0;
    if (tick_reg && en_sync) begin
      if (dir_sync) begin
        if (units_reg == 4'd9) begin
          units_next = 4'd0;
          if (tens_reg == 4'd9) begin
            tens_next = 4'd0;
            wrap_next = 1'b1;
          end else begin
            tens_next = tens_reg + 4'd1;
          end
        end else begin
          units_next = units_reg + 4'd1;
        end
      end else begin
        if (units_reg == 4'd0) begin
          units_next = 4'd9;
          if (tens_reg == 4'd0) begin
            tens_next = 4'd9;
            wrap_next = 1'b1;
          end else begin
            tens_next = tens_reg - 4'd1;
          end
        end else begin
          units_next = units_reg - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      tens_reg  <= 4'd0;
      units_reg <= 4'd0;
      wrap_reg  <= 1'b0;
    end else begin
      tens_reg  <= tens_next;
      units_reg <= units_next;
      wrap_reg  <= wrap_next;
    end
  end

  // ---------------- refresh / multiplex ----------------
  logic [REF_W-1:0] refresh_reg, refresh_next;
  digit_sel_t       sel_reg, sel_next;
  logic [6:0]       seg_reg;
  logic [1:0]       an_reg;
  bcd_t             shown_digit;
  logic [6:0]       shown_pattern;

  always_comb begin
    refresh_next = refresh_reg + REF_W'(1);
    sel_next     = sel_reg;
    if (refresh_reg == REF_LAST) begin
      refresh_next = '0;
      sel_next     = (sel_reg == SEL_UNITS) ? SEL_TENS : SEL_UNITS;
    end
  end

  // Decoding the upcoming selection keeps seg and an aligned on the same edge.
  assign shown_digit = (sel_next == SEL_TENS) ? tens_reg : units_reg;

  bcd_to_7seg u_dec (
    .digit   (shown_digit),
    .pattern (shown_pattern)
  );

  always_ff @(posedge clock_in) begin
    if (reset) begin
      refresh_reg <= '0;
      sel_reg     <= SEL_UNITS;
      seg_reg     <= SEG_ZERO;
      an_reg      <= AN_UNITS;
    end else begin
      refresh_reg <= refresh_next;
      sel_reg     <= sel_next;
      seg_reg     <= shown_pattern;
      an_reg      <= (sel_next == SEL_TENS) ? AN_TENS : AN_UNITS;
    end
  end

  assign tens  = tens_reg;
  assign units = units_reg;
  assign wrap  = wrap_reg;
  assign seg   = seg_reg;
  assign an    = an_reg;

endmodule

// File: tb/tb_contador_ud_bcd.sv
// Bench for contador_ud_bcd: cycle-indexed reference model plus directed checks.
`timescale 1ns/1ps
module tb_contador_ud_bcd;

  localparam int RDIV = 4;
  localparam int MAXC = 16384;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       clk_slow = 1'b0;
  logic       dir      = 1'b1;
  logic       enable   = 1'b1;
  logic [3:0] tens, units;
  logic       wrap;
  logic [6:0] seg;
  logic [1:0] an;

  int tests = 0;
  int fails = 0;
  int wrap_seen = 0;

  contador_ud_bcd #(.REFRESH_DIV(RDIV)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .clk_slow (clk_slow),
    .dir      (dir),
    .enable   (enable),
    .tens     (tens),
    .units    (units),
    .wrap     (wrap),
    .seg      (seg),
    .an       (an)
  );

  always #5 clock_in = ~clock_in;

  logic [6:0] seg_table [0:9];
  initial begin
    seg_table[0] = 7'b1000000; seg_table[1] = 7'b1111001;
    seg_table[2] = 7'b0100100; seg_table[3] = 7'b0110000;
    seg_table[4] = 7'b0011001; seg_table[5] = 7'b0010010;
    seg_table[6] = 7'b0000010; seg_table[7] = 7'b1111000;
    seg_table[8] = 7'b0000000; seg_table[9] = 7'b0010000;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each edge k records the sampled inputs; a count happens at
  // edge k when a genuine 0->1 of clk_slow was sampled at edge k-3, using the
  // dir/enable levels sampled at edge k-2. Display slot = (edges since reset)/RDIV.
  bit s_slow [0:MAXC-1];
  bit s_dir  [0:MAXC-1];
  bit s_en   [0:MAXC-1];
  int cnt_hist [0:MAXC-1];
  int cyc = 0;
  int last_rst = -1000;
  bit started = 0;
  int m_count = 0;
  bit m_wrap = 0;
  logic [6:0] e_seg;
  logic [1:0] e_an;

  always @(posedge clock_in) begin
    int j, slot, prev;
    if (cyc < MAXC) begin
      s_slow[cyc] = clk_slow;
      s_dir[cyc]  = dir;
      s_en[cyc]   = enable;
      m_wrap = 0;
      if (reset) begin
        last_rst = cyc;
        started  = 1;
        m_count  = 0;
      end else if (started) begin
        j = cyc - 3;
        if (j - 1 > last_rst && s_slow[j] && !s_slow[j-1] && s_en[cyc-2]) begin
          if (s_dir[cyc-2]) begin
            m_wrap  = (m_count == 99);
            m_count = (m_count + 1) % 100;
          end else begin
            m_wrap  = (m_count == 0);
            m_count = (m_count + 99) % 100;
          end
        end
      end
      cnt_hist[cyc] = m_count;
      if (started) begin
        slot = ((cyc - last_rst) / RDIV) % 2;
        prev = (cyc == last_rst) ? 0 : cnt_hist[cyc-1];
        e_an  = slot ? 2'b01 : 2'b10;
        e_seg = slot ? seg_table[prev / 10] : seg_table[prev % 10];
      end
      cyc++;
    end
  end

  always @(negedge clock_in) begin
    if (started) begin
      check("tens",  int'(tens),  m_count / 10);
      check("units", int'(units), m_count % 10);
      check("wrap",  int'(wrap),  int'(m_wrap));
      check("an",    int'(an),    int'(e_an));
      check("seg",   int'(seg),   int'(e_seg));
      if (wrap === 1'b1) wrap_seen++;
    end
  end

  task automatic pulse();
    clk_slow = 1'b0;
    repeat (10) @(negedge clock_in);
    clk_slow = 1'b1;
    repeat (10) @(negedge clock_in);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic check_count(input string name, input int exp);
    check({name, "_tens"},  int'(tens),  exp / 10);
    check({name, "_units"}, int'(units), exp % 10);
  endtask

  initial begin
    int wrap_before, n;
    bit found;

    // reset, then count up 12
    repeat (3) @(negedge clock_in);
    check_count("reset", 0);
    check("reset_an",  int'(an),  2);
    check("reset_seg", int'(seg), 7'b1000000);
    check("reset_wrap", int'(wrap), 0);
    reset = 1'b0;
    pulses(12);
    check_count("up12", 12);
    $display("[TB] up 12 rises -> %0d%0d", tens, units);

    // 97 -> 98 -> 99 -> 00
    pulses(85);
    check_count("pre97", 97);
    wrap_before = wrap_seen;
    pulses(3);
    check_count("wrap_up", 0);
    check("wrap_up_pulses", wrap_seen - wrap_before, 1);
    $display("[TB] up wrap -> %0d%0d", tens, units);

    // down: 00 -> 99 -> 98, then 10 -> 09
    dir = 1'b0;
    repeat (4) @(negedge clock_in);
    wrap_before = wrap_seen;
    pulse();
    check_count("down99", 99);
    pulse();
    check_count("down98", 98);
    check("wrap_down_pulses", wrap_seen - wrap_before, 1);
    pulses(88);
    check_count("down10", 10);
    pulse();
    check_count("down09", 9);
    $display("[TB] down borrow -> %0d%0d", tens, units);

    // enable low freezes the count
    dir = 1'b1;
    enable = 1'b0;
    repeat (4) @(negedge clock_in);
    wrap_before = wrap_seen;
    pulses(5);
    check_count("frozen", 9);
    check("frozen_wrap", wrap_seen - wrap_before, 0);
    enable = 1'b1;
    repeat (4) @(negedge clock_in);

    // dir flips inside the tick cycle: old synchronized value (up) wins
    clk_slow = 1'b0;
    repeat (10) @(negedge clock_in);
    clk_slow = 1'b1;
    repeat (3) @(negedge clock_in);
    dir = 1'b0;
    repeat (7) @(negedge clock_in);
    check_count("dir_tick", 10);
    pulse();
    check_count("dir_after", 9);
    $display("[TB] dir on tick -> %0d%0d", tens, units);

    // display at 37
    reset = 1'b1;
    dir = 1'b1;
    @(negedge clock_in);
    reset = 1'b0;
    check_count("reset2", 0);
    pulses(37);
    check_count("disp37", 37);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clock_in);
      if (an === 2'b01) found = 1;
    end
    check("an_tens_seen", int'(found), 1);
    check("seg_tens3", int'(seg), 7'b0110000);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clock_in);
      if (an === 2'b10) found = 1;
    end
    check("an_units_seen", int'(found), 1);
    check("seg_units7", int'(seg), 7'b1111000);
    n = 1;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clock_in);
      if (an === 2'b01) found = 1; else n++;
    end
    check("an_slot_len", n, RDIV);
    $display("[TB] display slot %0d cycles, seg=%b an=%b", n, seg, an);

    // reset mid-count at 45 with clk_slow held high
    pulses(8);
    check_count("pre45", 45);
    reset = 1'b1;
    @(negedge clock_in);
    check_count("mid_reset", 0);
    reset = 1'b0;
    repeat (20) @(negedge clock_in);
    check_count("held_high", 0);
    pulse();
    check_count("first_rise", 1);
    $display("[TB] reset with slow high -> %0d%0d", tens, units);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
